// File: rtl/gmux_seq_pkg.sv
// Shared types and constants for the AP3 global clock mux quadrant sequencer.
package gmux_seq_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_SWITCH,
      ST_APPLY,
      ST_ENABLE
   } seq_state_t;

   localparam int Q_TL = 0;
   localparam int Q_TR = 1;
   localparam int Q_BL = 2;
   localparam int Q_BR = 3;

   localparam logic SSEL_GCLKIN = 1'b0;
   localparam logic SSEL_GHSCK  = 1'b1;

   localparam int CNT_W = 8;
endpackage

// File: rtl/gmux_seq_pick.sv
// Lowest-set-bit picker over the pending quadrant mask (TL has priority).
module gmux_seq_pick (
   input  logic [3:0] mask,
   output logic [3:0] pick,
   output logic       empty
);
   // Two's-complement isolate of the lowest set bit.
   assign pick  = mask & (~mask + 4'd1);
   assign empty = (mask == 4'd0);
endmodule

// File: rtl/gmux_quad_sequencer.sv
// Glitch-safe source/quadrant sequencer in front of the AP3 global clock mux.
// Build option: GMUX_QUAD_SEQUENCER_STAGGER_EN staggers quadrant SEN rises.
//
// state     | meaning
// ST_IDLE   | ready for a request; outputs hold last applied config
// ST_DRAIN  | SEN forced low, waiting before SSEL may change
// ST_SWITCH | SSEL changed, waiting for the mux source to settle
// ST_APPLY  | same-source path: one cycle before DEN/DYNEN/VLP update
// ST_ENABLE | raising pending SEN bits, then DONE
module gmux_quad_sequencer #(
   parameter int DRAIN_CYC   = 4,
   parameter int SETTLE_CYC  = 2,
   parameter int STAGGER_CYC = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CFG_VALID,
   output logic       CFG_READY,
   input  logic       CFG_SSEL,
   input  logic [3:0] CFG_QEN,
   input  logic [3:0] CFG_DYN,
   output logic       SSEL,
   output logic [3:0] DEN,
   output logic [3:0] DYNEN,
   output logic [3:0] SEN,
   output logic [3:0] VLP,
   output logic       DONE
);
   import gmux_seq_pkg::*;

`ifdef GMUX_QUAD_SEQUENCER_STAGGER_EN
   localparam bit STAGGER_ON = 1'b1;
`else
   localparam bit STAGGER_ON = 1'b0;
`endif

   localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] STAG_LD   = STAGGER_ON ? CNT_W'(STAGGER_CYC - 1) : '0;

   seq_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             req_ssel, req_ssel_n;
   logic [3:0]       req_qen, req_qen_n, req_dyn, req_dyn_n;
   logic [3:0]       pend, pend_n;
   logic             ssel_n, ready_n, done_n;
   logic [3:0]       den_n, dynen_n, sen_n, vlp_n;
   logic [3:0]       pick, rise;
   logic             pend_empty;
   logic             apply_now;

   gmux_seq_pick u_pick (
      .mask  (pend),
      .pick  (pick),
      .empty (pend_empty)
   );

   // Without staggering every pending quadrant rises in the same cycle.
   assign rise = STAGGER_ON ? pick : pend;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         req_ssel  <= SSEL_GCLKIN;
         req_qen   <= 4'h0;
         req_dyn   <= 4'h0;
         pend      <= 4'h0;
         SSEL      <= SSEL_GCLKIN;
         DEN       <= 4'h0;
         DYNEN     <= 4'h0;
         SEN       <= 4'h0;
         VLP       <= 4'hF;
         DONE      <= 1'b0;
         CFG_READY <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         req_ssel  <= req_ssel_n;
         req_qen   <= req_qen_n;
         req_dyn   <= req_dyn_n;
         pend      <= pend_n;
         SSEL      <= ssel_n;
         DEN       <= den_n;
         DYNEN     <= dynen_n;
         SEN       <= sen_n;
         VLP       <= vlp_n;
         DONE      <= done_n;
         CFG_READY <= ready_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      req_ssel_n = req_ssel;
      req_qen_n  = req_qen;
      req_dyn_n  = req_dyn;
      pend_n     = pend;
      ssel_n     = SSEL;
      den_n      = DEN;
      dynen_n    = DYNEN;
      sen_n      = SEN;
      vlp_n      = VLP;
      done_n     = 1'b0;
      ready_n    = CFG_READY;
      apply_now  = 1'b0;

      case (state)
         ST_IDLE: begin
            ready_n = 1'b1;
            if (CFG_VALID && CFG_READY) begin
               ready_n    = 1'b0;
               req_ssel_n = CFG_SSEL;
               req_qen_n  = CFG_QEN;
               req_dyn_n  = CFG_DYN;
               if (CFG_SSEL != SSEL) begin
                  sen_n   = 4'h0;
                  cnt_n   = DRAIN_LD;
                  state_n = ST_DRAIN;
               end else begin
                  sen_n   = SEN & CFG_QEN;
                  state_n = ST_APPLY;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt == '0) begin
               ssel_n  = req_ssel;
               cnt_n   = SETTLE_LD;
               state_n = ST_SWITCH;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         ST_SWITCH: begin
            if (cnt == '0) apply_now = 1'b1;
            else           cnt_n = cnt - CNT_W'(1);
         end
         ST_APPLY: apply_now = 1'b1;
         ST_ENABLE: begin
            if (pend_empty) begin
               done_n  = 1'b1;
               ready_n = 1'b1;
               state_n = ST_IDLE;
            end else if (cnt == '0) begin
               sen_n  = SEN | rise;
               pend_n = pend & ~rise;
               cnt_n  = STAG_LD;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Pending set uses the SEN value already gated at the accepting edge.
      if (apply_now) begin
         den_n   = req_qen;
         dynen_n = req_qen & req_dyn;
         vlp_n   = ~req_qen;
         pend_n  = req_qen & ~SEN;
         cnt_n   = '0;
         state_n = ST_ENABLE;
      end
   end
endmodule

// File: tb/tb_gmux_quad_sequencer.sv
// Scoreboard bench for gmux_quad_sequencer; expected per-edge outputs are
// built from the request timing formulas and compared edge by edge.
module tb_gmux_quad_sequencer;
   localparam int DRAIN_CYC   = 4;
   localparam int SETTLE_CYC  = 2;
   localparam int STAGGER_CYC = 3;
`ifdef GMUX_QUAD_SEQUENCER_STAGGER_EN
   localparam bit STAG = 1'b1;
`else
   localparam bit STAG = 1'b0;
`endif

   logic       CLK, RST, CFG_VALID, CFG_READY, CFG_SSEL, SSEL, DONE;
   logic [3:0] CFG_QEN, CFG_DYN, DEN, DYNEN, SEN, VLP;

   typedef struct {
      int         edge_n;
      logic       ssel;
      logic [3:0] den, dynen, vlp, sen;
      logic       done, ready;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic       m_ssel;
   logic [3:0] m_den, m_dyn, m_vlp, m_sen;
   logic       p_ssel;
   logic [3:0] p_den, p_sen;

   gmux_quad_sequencer #(
      .DRAIN_CYC   (DRAIN_CYC),
      .SETTLE_CYC  (SETTLE_CYC),
      .STAGGER_CYC (STAGGER_CYC)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CFG_VALID (CFG_VALID),
      .CFG_READY (CFG_READY),
      .CFG_SSEL  (CFG_SSEL),
      .CFG_QEN   (CFG_QEN),
      .CFG_DYN   (CFG_DYN),
      .SSEL      (SSEL),
      .DEN       (DEN),
      .DYNEN     (DYNEN),
      .SEN       (SEN),
      .VLP       (VLP),
      .DONE      (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ssel = 1'b0;
      m_den  = 4'h0;
      m_dyn  = 4'h0;
      m_vlp  = 4'hF;
      m_sen  = 4'h0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ssel"}, SSEL, 1'b0);
      chk({tag, "_den"}, DEN, 4'h0);
      chk({tag, "_dynen"}, DYNEN, 4'h0);
      chk({tag, "_sen"}, SEN, 4'h0);
      chk({tag, "_vlp"}, VLP, 4'hF);
      chk({tag, "_done"}, DONE, 1'b0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      CFG_VALID = 1'b0;
      @(posedge CLK); #1;
      chk_reset_vals("rst_held");
      chk("rst_held_ready", CFG_READY, 1'b0);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk_reset_vals("rst_rel");
      chk("rst_rel_ready", CFG_READY, 1'b1);
      model_reset();
   endtask

   task automatic push_timeline(input logic rs, input logic [3:0] q, input logic [3:0] d);
      exp_t       e;
      logic       chg;
      int         a, last, done_e, k;
      int         rise_e[4];
      logic [3:0] sen_e0, p;
      chg    = (rs != m_ssel);
      a      = chg ? DRAIN_CYC + SETTLE_CYC : 1;
      sen_e0 = chg ? 4'h0 : (m_sen & q);
      p      = q & ~sen_e0;
      k      = 0;
      last   = a;
      for (int i = 0; i < 4; i++) begin
         rise_e[i] = 1 << 20;
         if (p[i]) begin
            rise_e[i] = STAG ? a + 1 + k * STAGGER_CYC : a + 1;
            last = rise_e[i];
            k++;
         end
      end
      done_e = (p == 4'h0) ? a + 1 : last + 1;
      for (int t = 0; t <= done_e; t++) begin
         e.edge_n = t;
         e.ssel   = (chg && t >= DRAIN_CYC) ? rs : m_ssel;
         e.den    = (t >= a) ? q : m_den;
         e.dynen  = (t >= a) ? (q & d) : m_dyn;
         e.vlp    = (t >= a) ? ~q : m_vlp;
         e.sen    = sen_e0;
         for (int i = 0; i < 4; i++)
            if (rise_e[i] <= t) e.sen[i] = 1'b1;
         e.done   = (t == done_e);
         e.ready  = (t == done_e);
         sb_q.push_back(e);
      end
      m_ssel = rs;
      m_den  = q;
      m_dyn  = q & d;
      m_vlp  = ~q;
      m_sen  = q;
   endtask

   task automatic run_req(input logic rs, input logic [3:0] q, input logic [3:0] d,
                          input int abort_at);
      exp_t e;
      int   n;
      n = 0;
      while (!CFG_READY && n < 64) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("ready_wait", CFG_READY, 1'b1);
      if (!CFG_READY) return;
      CFG_VALID = 1'b1;
      CFG_SSEL  = rs;
      CFG_QEN   = q;
      CFG_DYN   = d;
      push_timeline(rs, q, d);
      while (sb_q.size() > 0) begin
         @(posedge CLK); #1;
         CFG_VALID = 1'b0;
         e = sb_q.pop_front();
         chk($sformatf("e%0d_ssel", e.edge_n), SSEL, e.ssel);
         chk($sformatf("e%0d_den", e.edge_n), DEN, e.den);
         chk($sformatf("e%0d_dynen", e.edge_n), DYNEN, e.dynen);
         chk($sformatf("e%0d_vlp", e.edge_n), VLP, e.vlp);
         chk($sformatf("e%0d_sen", e.edge_n), SEN, e.sen);
         chk($sformatf("e%0d_done", e.edge_n), DONE, e.done);
         chk($sformatf("e%0d_ready", e.edge_n), CFG_READY, e.ready);
         if (abort_at >= 0 && e.edge_n >= abort_at) begin
            sb_q.delete();
            break;
         end
      end
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         chk("inv_sen_den", SEN & ~DEN, 4'h0);
         chk("inv_ssel_hold", (SSEL != p_ssel) && ((p_sen | SEN) != 4'h0), 1'b0);
         chk("inv_den_fall", p_den & ~DEN & p_sen, 4'h0);
      end
      p_ssel = SSEL;
      p_den  = DEN;
      p_sen  = SEN;
   end

   initial begin
      RST = 1'b1;
      CFG_VALID = 1'b0;
      CFG_SSEL = 1'b0;
      CFG_QEN = 4'h0;
      CFG_DYN = 4'h0;
      p_ssel = 1'b0;
      p_den = 4'h0;
      p_sen = 4'h0;
      model_reset();
      #3;
      chk_reset_vals("por");
      do_reset();
      repeat (4) begin
         @(posedge CLK); #1;
         chk("idle_done", DONE, 1'b0);
         chk("idle_sen", SEN, 4'h0);
      end

      run_req(1'b0, 4'hF, 4'h5, -1);
      run_req(1'b1, 4'hF, 4'h5, -1);
      run_req(1'b1, 4'h3, 4'h0, -1);
      run_req(1'b1, 4'h6, 4'h2, -1);
      run_req(1'b1, 4'h6, 4'h2, -1);
      run_req(1'b0, 4'h9, 4'hF, -1);

      run_req(1'b1, 4'hF, 4'h0, DRAIN_CYC + 1);
      RST = 1'b1;
      #2;
      chk_reset_vals("async_rst");
      chk("async_rst_ready", CFG_READY, 1'b0);
      do_reset();
      run_req(1'b1, 4'hF, 4'h5, -1);

      for (int r = 0; r < 8; r++)
         run_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), -1);

      chk("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
